// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline writeback has priority, queued
// long-latency results drain on free cycles, with an age-forced grant.
module wb_port_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             pipe_rd_addr_i,
    input  logic [31:0]            pipe_rd_data_i,
    input  logic                   pipe_rd_wen_i,
    input  logic                   ll_valid_i,
    output logic                   ll_ready_o,
    input  logic [4:0]             ll_rd_addr_i,
    input  logic [31:0]            ll_rd_data_i,
    output logic [4:0]             rd_addr_o,
    output logic [31:0]            rd_data_o,
    output logic                   rd_wen_o,
    output logic                   stall_o,
    output logic [$clog2(DEPTH):0] ll_pending_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        FORCE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [4:0]    mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_nxt;
    logic          pipe_busy;
    logic          full;
    logic          push;
    logic          pop;
    logic          waw;
    logic          denied;
    logic          wen_sel;
    logic          stall_sel;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;

    assign pipe_busy    = pipe_rd_wen_i && (pipe_rd_addr_i != 5'd0);
    assign full         = (cnt == CW'(DEPTH));
    assign ll_ready_o   = !rst && !full;
    assign push         = ll_valid_i && ll_ready_o;
    assign head_addr    = mem_addr[rd_ptr];
    assign head_data    = mem_data[rd_ptr];
    assign waw          = pipe_busy && (head_addr == pipe_rd_addr_i);
    assign rd_wen_o     = wen_sel && !rst;
    assign stall_o      = stall_sel && !rst;
    assign ll_pending_o = rst ? '0 : cnt;

    always_comb begin
        rd_addr_o = pipe_rd_addr_i;
        rd_data_o = pipe_rd_data_i;
        wen_sel   = pipe_rd_wen_i;
        stall_sel = 1'b0;
        pop       = 1'b0;
        denied    = 1'b0;
        if (state != IDLE) begin
            // A same-register pipe write makes the queued older result dead.
            if (waw) begin
                pop = 1'b1;
            end else if (!pipe_busy || state == FORCE) begin
                pop       = 1'b1;
                rd_addr_o = head_addr;
                rd_data_o = head_data;
                wen_sel   = (head_addr != 5'd0);
                stall_sel = pipe_busy;
            end else begin
                denied = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_nxt   = cnt + CW'(push) - CW'(pop);
        wait_nxt  = wait_cnt;
        state_nxt = state;
        if (pop) begin
            wait_nxt = '0;
        end else if (denied && wait_cnt != WW'(MAX_WAIT)) begin
            wait_nxt = wait_cnt + WW'(1);
        end
        unique case (state)
            IDLE: begin
                if (push) state_nxt = PEND;
            end
            PEND: begin
                if (cnt_nxt == '0) begin
                    state_nxt = IDLE;
                end else if (wait_nxt == WW'(MAX_WAIT)) begin
                    state_nxt = FORCE;
                end
            end
            FORCE: begin
                state_nxt = (cnt_nxt == '0) ? IDLE : PEND;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            wait_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            wait_cnt <= wait_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= ll_rd_addr_i;
            mem_data[wr_ptr] <= ll_rd_data_i;
        end
    end

endmodule
